uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the FPGA system, directly downstream of the board-level `rxd` pin and upstream of the memory-mapped UART peripheral inside `system`. Synchronises the asynchronous serial line, recovers 8N1 frames by mid-bit sampling, and presents each byte on a one-entry valid/ready holding register. Reports framing errors and overruns as single-cycle pulses for the peripheral's status register.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz `cpuclk` / 115200 baud); legal range is 4 to 65535.
- `clk`  in  1  system clock (`cpuclk` domain).
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  raw serial line, asynchronous; idle level is 1.
- `rx_data`  out  8  received byte, valid while `rx_valid` is 1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; a transfer occurs when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled as 0.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the holding register is still full.

## Operation
- Two-flop synchroniser on `rxd` produces `rxd_s`. Both flops reset to 1.
- `HALF = CLKS_PER_BIT/2` (integer division). The bit counter is 16 bits wide and the bit index is 3 bits wide.
- **IDLE:** on `rxd_s == 0`, go to START with the counter cleared. Call this cycle t0.
- **START:** count up. At t0+HALF, sample `rxd_s`:
  - 0: go to DATA with the counter and bit index cleared.
  - 1: this was a glitch; return to IDLE with no outputs.
- **DATA:** bit i is sampled at t0+HALF+(i+1)·CLKS_PER_BIT, LSB first, into the shift register. After bit 7, go to STOP.
- **STOP:** sample at t0+HALF+9·CLKS_PER_BIT.
  - 1: the byte is good; deliver it to the holding register and return to IDLE.
  - 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- **WAIT_HIGH:** stay here until `rxd_s == 1`, then go to IDLE. A held-low line or break produces exactly one `frame_err`.
- Holding register, on good-byte delivery:
  - `rx_valid` is 0: load `rx_data` and set `rx_valid`.
  - `rx_valid` and `rx_ready` are both 1 in the same cycle: load the new byte; `rx_valid` stays 1.
  - `rx_valid` is 1 and `rx_ready` is 0: keep the old byte, drop the new one, and pulse `overrun`.
- With no delivery that cycle, `rx_valid && rx_ready` clears `rx_valid`. `rx_data` holds its last value.
- `rx_ready` while `rx_valid` is 0 has no effect.
- The receiver never stalls. Reception continues regardless of the holding register.

## Timing
- Reset values:
  - state IDLE; counter and bit index 0.
  - synchroniser flops 1.
  - `rx_data` 8'h00; `rx_valid`, `frame_err`, `overrun` all 0.
- Reset mid-frame aborts immediately. After release, the receiver restarts in IDLE and can mis-frame the remainder of the current frame. This is acceptable.
- `rxd_s` lags `rxd` by 2 cycles, so t0 is 2 or 3 cycles after the pin's falling edge.
- `rx_valid`, `frame_err` and `overrun` are registered and assert in cycle t0+HALF+9·CLKS_PER_BIT+1.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit sample point, with the receiver back in IDLE. The minimum frame spacing is 10 bit times.
- All outputs come from flops. There is no combinational path from `rx_ready` to any output.

## Structure
- `uart_pkg` contains:
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - `UART_DATA_BITS = 8`.
  - `UART_DEFAULT_CLKS_PER_BIT = 434`.
- Sub-module `sync_2ff` is a generic two-flop synchroniser with a reset-value parameter. The future `uart_tx` and GPIO inputs will reuse it.
- The remaining logic (FSM, counter, shift register, holding register) lives in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT=16`.
- Send 8'hA5 with `rx_ready` held at 1 → `rx_valid` is high for exactly 1 cycle with `rx_data=8'hA5`, at t0+8+144+1 = t0+153; no error pulses.
- Send 8'h3C then 8'hC3 back-to-back with `rx_ready=0` → `rx_data` stays 8'h3C, `overrun` pulses once at the second delivery. Then raise `rx_ready` → one transfer of 8'h3C, after which `rx_valid=0`.
- Send 8'h55 with a 0 stop bit → `frame_err` pulses once, `rx_valid` stays 0. Hold the line low for 40 cycles, then release → no second `frame_err`. A following frame with 8'h81 is received correctly.
- Apply a 5-cycle low glitch on idle `rxd` → return to IDLE with no outputs. A following frame with 8'h00 is received correctly.
- Assert `rst` mid-DATA of 8'hFF → all outputs go to 0 asynchronously and the state is IDLE. A following frame with 8'h12 is received correctly.
- In the delivery cycle of 8'h7E, drive `rx_valid=1` (old byte 8'h11) and `rx_ready=1` → `rx_data=8'h7E`, `rx_valid` stays 1, no `overrun`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame geometry and
// baud-rate defaults. Imported by uart_rx and, later, uart_tx.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int unsigned UART_CNT_W                = 16;
  localparam int unsigned UART_IDX_W                = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // Terminal count for the half-bit wait that lands on the start-bit centre.
  function automatic logic [UART_CNT_W-1:0] uart_half_last(input int unsigned cpb);
    return UART_CNT_W'((cpb / 2) - 1);
  endfunction

  // Terminal count for one full bit period.
  function automatic logic [UART_CNT_W-1:0] uart_bit_last(input int unsigned cpb);
    return UART_CNT_W'(cpb - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, both stages load RESET_VAL
//   d    - asynchronous input
//   q    - synchronised output, two cycles behind d
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready
// holding register.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   rxd       - raw serial line (asynchronous, idles high)
//   rx_data   - received byte, meaningful while rx_valid is high
//   rx_valid  - holding register full
//   rx_ready  - consumer accepts the held byte (transfer on valid && ready)
//   frame_err - one-cycle pulse when the stop bit samples low
//   overrun   - one-cycle pulse when a good byte is dropped on a full register
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam logic [UART_CNT_W-1:0] HALF_LAST = uart_half_last(CLKS_PER_BIT);
  localparam logic [UART_CNT_W-1:0] BIT_LAST  = uart_bit_last(CLKS_PER_BIT);
  localparam logic [UART_IDX_W-1:0] IDX_LAST  = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  uart_rx_state_t            state_nxt;
  logic                      rxd_s;
  logic [UART_CNT_W-1:0]     cnt;
  logic [UART_IDX_W-1:0]     bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;

  logic half_hit_c;
  logic bit_hit_c;
  logic cnt_clr_c;
  logic idx_clr_c;
  logic shift_en_c;
  logic deliver_c;
  logic ferr_c;

  // Bring the pin into the clk domain; idle level is 1 so reset to 1.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  assign half_hit_c = (cnt == HALF_LAST);
  assign bit_hit_c  = (cnt == BIT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!rxd_s) state_nxt = START;
      end
      START: begin
        // Still low at the start-bit centre means a real frame, else a glitch.
        if (half_hit_c) state_nxt = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_hit_c && (bit_idx == IDX_LAST)) state_nxt = STOP;
      end
      STOP: begin
        if (bit_hit_c) state_nxt = rxd_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        // Absorb a held-low line so a break reports only one frame error.
        if (rxd_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    cnt_clr_c  = 1'b0;
    idx_clr_c  = 1'b0;
    shift_en_c = 1'b0;
    deliver_c  = 1'b0;
    ferr_c     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr_c = 1'b1;
        idx_clr_c = 1'b1;
      end
      START: begin
        if (half_hit_c) begin
          cnt_clr_c = 1'b1;
          idx_clr_c = 1'b1;
        end
      end
      DATA: begin
        if (bit_hit_c) begin
          cnt_clr_c  = 1'b1;
          shift_en_c = 1'b1;
        end
      end
      STOP: begin
        if (bit_hit_c) begin
          cnt_clr_c = 1'b1;
          deliver_c = rxd_s;
          ferr_c    = !rxd_s;
        end
      end
      WAIT_HIGH: begin
        cnt_clr_c = 1'b1;
        idx_clr_c = 1'b1;
      end
      default: begin
        cnt_clr_c = 1'b1;
        idx_clr_c = 1'b1;
      end
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      cnt <= cnt_clr_c ? '0 : cnt + UART_CNT_W'(1);
      if (idx_clr_c) begin
        bit_idx <= '0;
      end else if (shift_en_c) begin
        bit_idx <= bit_idx + UART_IDX_W'(1);
      end
      if (shift_en_c) begin
        shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
      end
    end
  end

  // Holding register and status pulses. A simultaneous pop frees the slot
  // for the arriving byte, so only a full, unaccepted register overruns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_c;
      overrun   <= 1'b0;
      if (deliver_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       rxd      = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int unsigned cyc      = 0;
  int unsigned last_e0  = 0;
  int unsigned rise_cyc = 0;
  int          n_ferr   = 0;
  int          n_ovr    = 0;
  int          n_vhigh  = 0;
  int          n_rise   = 0;
  logic        valid_q  = 1'b0;
  logic [7:0]  got[$];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: consumed bytes, pulses and valid activity.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (rx_valid) n_vhigh++;
    if (rx_valid && !valid_q) begin
      rise_cyc = cyc;
      n_rise++;
    end
    valid_q = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; each bit held for CPB cycles. Line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    logic [9:0] bits;
    bits = {stop_b, b, 1'b0};
    @(posedge clk);
    #1;
    last_e0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      step(CPB);
    end
  endtask

  initial begin
    int         bf, bo, bv, br, bg;
    int         exp_f;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       bad;

    // Reset state
    step(3);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    step(5);

    // Single byte with ready held high: one-cycle valid at t0+153
    rx_ready = 1'b1;
    bf = n_ferr; bo = n_ovr; bv = n_vhigh; bg = got.size();
    send_frame(8'hA5, 1'b1);
    step(5);
    check("a5_latency", 32'(rise_cyc), 32'(last_e0 + 155));
    check("a5_valid_cycles", 32'(n_vhigh - bv), 32'd1);
    check("a5_count", 32'(got.size()), 32'(bg + 1));
    if (got.size() > bg) check("a5_data", 32'(got[bg]), 32'hA5);
    check("a5_ferr", 32'(n_ferr - bf), 32'd0);
    check("a5_ovr", 32'(n_ovr - bo), 32'd0);

    // Overrun: second byte dropped while the first waits
    rx_ready = 1'b0;
    bo = n_ovr; bg = got.size();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    step(3);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h3C);
    check("ovr_pulses", 32'(n_ovr - bo), 32'd1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    check("ovr_drain_valid", 32'(rx_valid), 32'd0);
    check("ovr_drain_count", 32'(got.size()), 32'(bg + 1));
    if (got.size() > bg) check("ovr_drain_data", 32'(got[bg]), 32'h3C);

    // Framing error followed by a held-low line
    rx_ready = 1'b1;
    bf = n_ferr; bv = n_vhigh;
    send_frame(8'h55, 1'b0);
    step(40);
    rxd = 1'b1;
    step(20);
    check("ferr_once", 32'(n_ferr - bf), 32'd1);
    check("ferr_no_valid", 32'(n_vhigh - bv), 32'd0);
    bg = got.size();
    send_frame(8'h81, 1'b1);
    step(3);
    check("ferr_next_count", 32'(got.size()), 32'(bg + 1));
    if (got.size() > bg) check("ferr_next_data", 32'(got[bg]), 32'h81);
    check("ferr_still_once", 32'(n_ferr - bf), 32'd1);

    // Short low glitch on an idle line
    rx_ready = 1'b0;
    bf = n_ferr; br = n_rise;
    rxd = 1'b0;
    step(5);
    rxd = 1'b1;
    step(30);
    check("glitch_no_valid", 32'(n_rise - br), 32'd0);
    check("glitch_no_ferr", 32'(n_ferr - bf), 32'd0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    send_frame(8'h00, 1'b1);
    step(3);
    check("glitch_next_valid", 32'(rx_valid), 32'd1);
    check("glitch_next_data", 32'(rx_data), 32'h00);

    // Asynchronous reset in the middle of a frame of 8'hFF
    rxd = 1'b0;
    step(CPB);
    rxd = 1'b1;
    step(40);
    check("rst_pre_state", 32'(dut.state), 32'(DATA));
    check("rst_pre_valid", 32'(rx_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(rx_valid), 32'd0);
    check("rst_async_data", 32'(rx_data), 32'h00);
    check("rst_async_ferr", 32'(frame_err), 32'd0);
    check("rst_async_ovr", 32'(overrun), 32'd0);
    check("rst_async_state", 32'(dut.state), 32'(IDLE));
    step(2);
    rst = 1'b0;
    step(20);
    rx_ready = 1'b1;
    bg = got.size();
    send_frame(8'h12, 1'b1);
    step(3);
    check("rst_next_count", 32'(got.size()), 32'(bg + 1));
    if (got.size() > bg) check("rst_next_data", 32'(got[bg]), 32'h12);

    // Pop and delivery in the same cycle
    rx_ready = 1'b0;
    bo = n_ovr;
    send_frame(8'h11, 1'b1);
    step(3);
    check("same_old_data", 32'(rx_data), 32'h11);
    bg = got.size();
    fork
      send_frame(8'h7E, 1'b1);
      begin
        @(posedge clk);
        step(154);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
      end
    join
    check("same_valid", 32'(rx_valid), 32'd1);
    check("same_data", 32'(rx_data), 32'h7E);
    check("same_no_ovr", 32'(n_ovr - bo), 32'd0);
    check("same_pop_count", 32'(got.size()), 32'(bg + 1));
    if (got.size() > bg) check("same_pop_data", 32'(got[bg]), 32'h11);
    rx_ready = 1'b1;
    step(3);

    // Random frames, some with bad stop bits, random idle gaps
    bf = n_ferr; bo = n_ovr; bg = got.size();
    exp_f = 0;
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad);
      if (bad) begin
        exp_f++;
        step(int'($urandom_range(2, 8)));
        rxd = 1'b1;
        step(2);
      end else begin
        exp_q.push_back(b);
      end
      step(int'($urandom_range(0, 12)));
    end
    step(5);
    check("rand_count", 32'(got.size() - bg), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bg + i < got.size()) check($sformatf("rand_byte%0d", i), 32'(got[bg + i]), 32'(exp_q[i]));
    end
    check("rand_ferr", 32'(n_ferr - bf), 32'(exp_f));
    check("rand_ovr", 32'(n_ovr - bo), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
